// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_sup_pkg
// Purpose  : Shared state type and default timing constants for the PLL
//            lock supervisor.
// Revision : 1.0 - initial release
// ============================================================================
package pll_sup_pkg;

    typedef enum logic [1:0] {
        ST_PLLRST   = 2'd0,
        ST_WAITLOCK = 2'd1,
        ST_STABLE   = 2'd2,
        ST_RUN      = 2'd3
    } pll_sup_state_t;

    localparam int C_DEF_RST_PULSE_CYC    = 16;
    localparam int C_DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int C_DEF_STABLE_CYC       = 1024;
    localparam int C_DEF_SYNC_STAGES      = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_supervisor_sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_bit
// Purpose  : Multi-flop synchronizer for a single asynchronous level
//            (SYNC_STAGES legal range 2..4).
// Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Sequences PLL reset, lock wait, lock qualification and system
//            reset release. Optional macro PLL_SUP_RETRY_CNT_EN enables the
//            saturating re-reset counter on retry_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = C_DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = C_DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = C_DEF_STABLE_CYC,
    parameter int SYNC_STAGES      = C_DEF_SYNC_STAGES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    localparam int c_cnt_w = $clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC)) + 1;

    localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_PULSE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_stb_last = c_cnt_w'(STABLE_CYC - 1);

    logic               w_locked_s;
    pll_sup_state_t     r_state;
    pll_sup_state_t     w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_next_cnt;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_lock_lost;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_locked (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (w_locked_s)
    );

    // One counter serves every state; it is cleared on each state change.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 1'b1;
        case (r_state)
            ST_PLLRST: begin
                if (r_cnt == c_rst_last) begin
                    w_next_state = ST_WAITLOCK;
                    w_next_cnt   = '0;
                end
            end
            ST_WAITLOCK: begin
                // Lock is tested first so a coincident timeout loses.
                if (w_locked_s) begin
                    w_next_state = ST_STABLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_tmo_last) begin
                    w_next_state = ST_PLLRST;
                    w_next_cnt   = '0;
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_next_state = ST_WAITLOCK;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_stb_last) begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end
            end
            ST_RUN: begin
                w_next_cnt = '0;
                if (!w_locked_s) begin
                    w_next_state = ST_PLLRST;
                end
            end
            default: begin
                w_next_state = ST_PLLRST;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_PLLRST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_pll_rst   <= (w_next_state == ST_PLLRST);
            r_sys_rst   <= (w_next_state != ST_RUN);
            r_ready     <= (w_next_state == ST_RUN);
            r_lock_lost <= (r_state == ST_RUN) && (w_next_state == ST_PLLRST);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

`ifdef PLL_SUP_RETRY_CNT_EN
    logic [7:0] r_retry_cnt;
    logic       w_retry_evt;

    // Only WAITLOCK timeouts and RUN lock loss can re-enter PLLRST.
    assign w_retry_evt = (w_next_state == ST_PLLRST) && (r_state != ST_PLLRST);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_retry_cnt <= 8'h00;
        end else if (w_retry_evt && (r_retry_cnt != 8'hFF)) begin
            r_retry_cnt <= r_retry_cnt + 8'h01;
        end
    end

    assign retry_cnt = r_retry_cnt;
`else
    assign retry_cnt = 8'h00;
`endif

endmodule
`default_nettype wire
